// File: rtl/mb_univ_reg.sv
// mb_univ_reg: WIDTH-bit universal register with hold, load, shift,
// rotate, increment and decrement. Co carries the shifted-out bit or the
// wrap carry/borrow, always derived from the pre-edge contents.
module mb_univ_reg #(
    parameter int unsigned            WIDTH   = 8,
    parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
    input  logic             Cp,
    input  logic             Rn,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SR_in,
    input  logic             SL_in,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             Co,
    output logic             Zero
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHR  = 3'b001,
        M_SHL  = 3'b010,
        M_LOAD = 3'b011,
        M_INC  = 3'b100,
        M_DEC  = 3'b101,
        M_ROR  = 3'b110,
        M_ROL  = 3'b111
    } mode_t;

    logic [WIDTH-1:0] r_q;
    logic             r_co;
    logic [WIDTH-1:0] w_nxt_q;
    logic             w_nxt_co;
    mode_t            w_mode;

    assign w_mode = mode_t'(Mode);

    // Next-state selection; En=0 degenerates to hold with Co cleared.
    always_comb begin
        w_nxt_q  = r_q;
        w_nxt_co = 1'b0;
        if (En) begin
            case (w_mode)
                M_HOLD: begin
                    w_nxt_q  = r_q;
                    w_nxt_co = 1'b0;
                end
                M_SHR: begin
                    w_nxt_q  = {SR_in, r_q[WIDTH-1:1]};
                    w_nxt_co = r_q[0];
                end
                M_SHL: begin
                    w_nxt_q  = {r_q[WIDTH-2:0], SL_in};
                    w_nxt_co = r_q[WIDTH-1];
                end
                M_LOAD: begin
                    w_nxt_q  = D;
                    w_nxt_co = 1'b0;
                end
                M_INC: begin
                    w_nxt_q  = r_q + 1'b1;
                    w_nxt_co = &r_q;
                end
                M_DEC: begin
                    w_nxt_q  = r_q - 1'b1;
                    w_nxt_co = ~|r_q;
                end
                M_ROR: begin
                    w_nxt_q  = {r_q[0], r_q[WIDTH-1:1]};
                    w_nxt_co = r_q[0];
                end
                M_ROL: begin
                    w_nxt_q  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    w_nxt_co = r_q[WIDTH-1];
                end
                default: begin
                    w_nxt_q  = r_q;
                    w_nxt_co = 1'b0;
                end
            endcase
        end
    end

    // State register; asynchronous clear overrides any concurrent edge.
    always_ff @(posedge Cp or negedge Rn) begin
        if (!Rn) begin
            r_q  <= RST_VAL;
            r_co <= 1'b0;
        end else begin
            r_q  <= w_nxt_q;
            r_co <= w_nxt_co;
        end
    end

    assign Q    = r_q;
    assign Qn   = ~r_q;
    assign Co   = r_co;
    assign Zero = (r_q == '0);

endmodule

// File: tb/tb_mb_univ_reg.sv
// Directed bench for mb_univ_reg: an 8-bit instance with RST_VAL=A5 and a
// 4-bit instance with RST_VAL=0 share clock and reset.
module tb_mb_univ_reg;

    logic       Cp = 1'b0;
    logic       Rn = 1'b1;
    logic       SR_in = 1'b0;
    logic       SL_in = 1'b0;

    logic       En = 1'b0;
    logic [2:0] Mode = 3'b000;
    logic [7:0] D = 8'h00;
    logic [7:0] Q, Qn;
    logic       Co, Zero;

    logic       En4 = 1'b0;
    logic [2:0] Mode4 = 3'b000;
    logic [3:0] D4 = 4'h0;
    logic [3:0] Q4, Qn4;
    logic       Co4, Zero4;

    int total = 0;
    int bad   = 0;

    mb_univ_reg #(.WIDTH(8), .RST_VAL(8'hA5)) u8 (
        .Cp(Cp), .Rn(Rn), .En(En), .Mode(Mode), .D(D),
        .SR_in(SR_in), .SL_in(SL_in),
        .Q(Q), .Qn(Qn), .Co(Co), .Zero(Zero)
    );

    mb_univ_reg #(.WIDTH(4), .RST_VAL(4'h0)) u4 (
        .Cp(Cp), .Rn(Rn), .En(En4), .Mode(Mode4), .D(D4),
        .SR_in(SR_in), .SL_in(SL_in),
        .Q(Q4), .Qn(Qn4), .Co(Co4), .Zero(Zero4)
    );

    always #5 Cp = ~Cp;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge Cp);
        #1;
    endtask

    task automatic op(input logic [2:0] m);
        En   = 1'b1;
        Mode = m;
        step();
    endtask

    task automatic chk8(input string tag, input logic [7:0] q, input logic co);
        check({tag, "_q"}, Q, q);
        check({tag, "_co"}, {7'd0, Co}, {7'd0, co});
    endtask

    initial begin
        // Power-on reset
        #1 Rn = 1'b0;
        #2;
        check("por_q", Q, 8'hA5);
        check("por_qn", Qn, 8'h5A);
        check("por_co", {7'd0, Co}, 8'd0);
        check("por_zero", {7'd0, Zero}, 8'd0);
        check("por_q4", {4'd0, Q4}, 8'h00);
        check("por_zero4", {7'd0, Zero4}, 8'd1);
        #4 Rn = 1'b1;

        // Load 3C, then async reset between edges
        D = 8'h3C; op(3'b011);
        chk8("ld3c", 8'h3C, 1'b0);
        #2 Rn = 1'b0;
        #1;
        check("arst_q", Q, 8'hA5);
        check("arst_qn", Qn, 8'h5A);
        check("arst_co", {7'd0, Co}, 8'd0);
        // Edge while in reset is ignored
        D = 8'hFF; op(3'b011);
        check("rst_edge_q", Q, 8'hA5);
        Rn = 1'b1;

        // Load and hold
        D = 8'h81; op(3'b011);
        chk8("ld81", 8'h81, 1'b0);
        op(3'b000);
        chk8("hold", 8'h81, 1'b0);
        En = 1'b0; Mode = 3'b011; D = 8'hFF; step();
        chk8("en0", 8'h81, 1'b0);

        // Shifts
        SR_in = 1'b1; op(3'b001);
        chk8("shr", 8'hC0, 1'b1);
        SL_in = 1'b0; op(3'b010);
        chk8("shl1", 8'h80, 1'b1);
        op(3'b010);
        chk8("shl2", 8'h00, 1'b1);
        check("shl2_zero", {7'd0, Zero}, 8'd1);

        // Rotates
        D = 8'h01; op(3'b011);
        op(3'b110);
        chk8("ror", 8'h80, 1'b1);
        op(3'b111);
        chk8("rol1", 8'h01, 1'b1);
        op(3'b111);
        chk8("rol2", 8'h02, 1'b0);

        // Counter wrap
        D = 8'hFE; op(3'b011);
        op(3'b100);
        chk8("inc1", 8'hFF, 1'b0);
        op(3'b100);
        chk8("inc2", 8'h00, 1'b1);
        check("inc2_zero", {7'd0, Zero}, 8'd1);
        op(3'b101);
        chk8("dec", 8'hFF, 1'b1);
        check("dec_qn", Qn, 8'h00);
        op(3'b000);
        chk8("co_pulse", 8'hFF, 1'b0);

        // Reset coincident with the edge at Q=05
        D = 8'h00; op(3'b011);
        for (int i = 0; i < 5; i++) op(3'b100);
        chk8("cnt5", 8'h05, 1'b0);
        @(posedge Cp);
        Rn = 1'b0;
        #1;
        chk8("mid_rst", 8'hA5, 1'b0);
        #3 Rn = 1'b1;
        step();
        chk8("post_rel", 8'hA6, 1'b0);

        // 4-bit instance wrap
        En = 1'b0;
        En4 = 1'b1; Mode4 = 3'b011; D4 = 4'hE; step();
        check("w4_ld", {4'd0, Q4}, 8'h0E);
        Mode4 = 3'b100; step();
        check("w4_inc1", {4'd0, Q4}, 8'h0F);
        check("w4_inc1_co", {7'd0, Co4}, 8'd0);
        step();
        check("w4_inc2", {4'd0, Q4}, 8'h00);
        check("w4_inc2_co", {7'd0, Co4}, 8'd1);
        check("w4_inc2_zero", {7'd0, Zero4}, 8'd1);
        Mode4 = 3'b101; step();
        check("w4_dec", {4'd0, Q4}, 8'h0F);
        check("w4_dec_co", {7'd0, Co4}, 8'd1);
        check("w4_dec_qn", {4'd0, Qn4}, 8'h00);
        check("u8_idle", Q, 8'hA6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
